// File: rtl/accel_uart_packetizer_pkg.sv
// Shared definitions for the accelerometer UART packetizer: frame layout,
// FSM state encodings and the frame checksum helper.
package accel_uart_packetizer_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES    = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  typedef enum logic {
    FRM_IDLE,
    FRM_SEND
  } frame_state_e;

  // Checksum covers the six sample bytes only; the header is constant.
  function automatic logic [7:0] frame_csum(input logic [15:0] xs,
                                            input logic [15:0] ys,
                                            input logic [15:0] zs);
    return xs[15:8] ^ xs[7:0] ^ ys[15:8] ^ ys[7:0] ^ zs[15:8] ^ zs[7:0];
  endfunction

endpackage

// File: rtl/accel_uart_packetizer_uart_tx.sv
// 8N1 UART transmitter. A start request in the same cycle as the done pulse
// chains the next byte back-to-back with no idle gap on the line.
module accel_uart_packetizer_uart_tx
  import accel_uart_packetizer_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             baud_end;

  assign baud_end = (cnt_q == CNT_LAST);
  assign tx       = tx_q;
  assign busy     = (state_q != UART_IDLE);

  // Bit sequencing: every bit is held for exactly BAUD_DIV cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done    = 1'b0;
    if (state_q != UART_IDLE) begin
      cnt_d = baud_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          cnt_d   = '0;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (baud_end) begin
          state_d = UART_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      UART_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      UART_STOP: begin
        if (baud_end) begin
          done = 1'b1;
          if (start) begin
            state_d = UART_START;
            shreg_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Control state with synchronous reset; line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/accel_uart_packetizer.sv
// Captures one x/y/z sample, frames it as HEADER + 6 data bytes + XOR
// checksum and streams the frame through the UART transmitter.
module accel_uart_packetizer
  import accel_uart_packetizer_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 100_000_000,
  parameter int         BAUD_RATE   = 115_200,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic        tx,
  output logic        busy,
  output logic        drop,
  output logic [15:0] frame_count
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;

  frame_state_e state_q, state_d;
  logic [2:0]   byte_idx_q, byte_idx_d;
  logic [15:0]  frame_count_q, frame_count_d;
  logic [15:0]  x_q, y_q, z_q;
  logic [7:0]   csum_q;
  logic [2:0]   next_idx;
  logic [7:0]   next_byte;
  logic         accept;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_done;
  logic         uart_busy;

  assign accept      = (state_q == FRM_IDLE) && !uart_busy && sample_valid && enable;
  assign busy        = (state_q == FRM_SEND);
  assign drop        = (state_q == FRM_SEND) && sample_valid && enable;
  assign frame_count = frame_count_q;
  assign next_idx    = byte_idx_q + 3'd1;

  // Byte that follows the one currently on the line.
  always_comb begin
    next_byte = HEADER;
    case (next_idx)
      3'd1:    next_byte = x_q[15:8];
      3'd2:    next_byte = x_q[7:0];
      3'd3:    next_byte = y_q[15:8];
      3'd4:    next_byte = y_q[7:0];
      3'd5:    next_byte = z_q[15:8];
      3'd6:    next_byte = z_q[7:0];
      3'd7:    next_byte = csum_q;
      default: next_byte = HEADER;
    endcase
  end

  // Frame FSM: header goes out on accept, later bytes chain on each done.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    frame_count_d = frame_count_q;
    tx_start      = 1'b0;
    tx_data       = HEADER;
    case (state_q)
      FRM_IDLE: begin
        if (accept) begin
          state_d    = FRM_SEND;
          byte_idx_d = 3'd0;
          tx_start   = 1'b1;
        end
      end
      FRM_SEND: begin
        if (tx_done) begin
          if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
            state_d       = FRM_IDLE;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            byte_idx_d = next_idx;
            tx_start   = 1'b1;
            tx_data    = next_byte;
          end
        end
      end
      default: state_d = FRM_IDLE;
    endcase
  end

  // Frame control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FRM_IDLE;
      byte_idx_q    <= 3'd0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sample latch: loaded only on accept, so overruns leave it untouched.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q    <= x;
      y_q    <= y;
      z_q    <= z;
      csum_q <= frame_csum(x, y, z);
    end
  end

  accel_uart_packetizer_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .busy (uart_busy),
    .done (tx_done)
  );

endmodule
